// File: rtl/vga_pkg.sv
// Shared VGA timing constants, region/state enums and the sync-level helper.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} region_e;
  typedef enum logic {IDLE, RUN} state_e;

  function automatic logic sync_level(region_e region, logic pol);
    return (region == SYNC) ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Pixel strobe/lock inputs and timing outputs of the VGA sync generator.
interface vga_sync_gen_if #(
  parameter int unsigned CNT_W = 10
);
  logic             pix_en;
  logic             locked;
  logic             hsync;
  logic             vsync;
  logic             video_on;
  logic [CNT_W-1:0] pixel_x;
  logic [CNT_W-1:0] pixel_y;
  logic             line_start;
  logic             frame_start;

  modport master (
    input  pix_en, locked,
    output hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start
  );

  modport slave (
    output pix_en, locked,
    input  hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping counter plus ACTIVE/FRONT/SYNC/BACK region FSM.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned CNT_W      = 10,
  parameter int unsigned SEG_ACTIVE = 640,
  parameter int unsigned SEG_FP     = 16,
  parameter int unsigned SEG_SYNC   = 96,
  parameter int unsigned SEG_BP     = 48
) (
  input  logic             clk_in1,
  input  logic             reset,
  input  logic             i_advance,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_count,
  output region_e          o_region,
  output region_e          o_region_nxt,
  output logic             o_wrap
);

  localparam int unsigned Total = SEG_ACTIVE + SEG_FP + SEG_SYNC + SEG_BP;
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(Total - 1);
  localparam logic [CNT_W-1:0] BndFront = CNT_W'(SEG_ACTIVE);
  localparam logic [CNT_W-1:0] BndSync = CNT_W'(SEG_ACTIVE + SEG_FP);
  localparam logic [CNT_W-1:0] BndBack = CNT_W'(SEG_ACTIVE + SEG_FP + SEG_SYNC);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_d;
  region_e          r_region;
  region_e          w_region_d;
  logic             w_wrap;

  assign w_wrap = i_advance && (r_count == LastCnt);

  always_comb begin
    w_count_d  = r_count;
    w_region_d = r_region;
    if (i_clear) begin
      w_count_d  = '0;
      w_region_d = ACTIVE;
    end else if (i_advance) begin
      w_count_d = w_wrap ? '0 : r_count + CNT_W'(1);
      // Region changes exactly when the new count hits a segment boundary.
      if (w_count_d == '0) begin
        w_region_d = ACTIVE;
      end else if (w_count_d == BndFront) begin
        w_region_d = FRONT;
      end else if (w_count_d == BndSync) begin
        w_region_d = SYNC;
      end else if (w_count_d == BndBack) begin
        w_region_d = BACK;
      end
    end
  end

  always_ff @(posedge clk_in1 or negedge reset) begin
    if (!reset) begin
      r_count  <= '0;
      r_region <= ACTIVE;
    end else begin
      r_count  <= w_count_d;
      r_region <= w_region_d;
    end
  end

  assign o_count      = r_count;
  assign o_region     = r_region;
  assign o_region_nxt = w_region_d;
  assign o_wrap       = w_wrap;

endmodule

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator driven by a pixel-rate enable on the system clock.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::V_BP,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned CNT_W    = 10
) (
  input logic            clk_in1,
  input logic            reset,
  vga_sync_gen_if.master bus
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (HTotal > (2 ** CNT_W)) begin : g_h_overflow
    $error("vga_sync_gen: horizontal total does not fit CNT_W");
  end
  if (VTotal > (2 ** CNT_W)) begin : g_v_overflow
    $error("vga_sync_gen: vertical total does not fit CNT_W");
  end

  state_e           r_state, w_state_d;
  logic             r_hsync, w_hsync_d;
  logic             r_vsync, w_vsync_d;
  logic             r_video_on, w_video_on_d;
  logic             r_line_start, w_line_start_d;
  logic             r_frame_start, w_frame_start_d;
  logic             w_running, w_h_adv, w_v_adv, w_clear;
  logic             w_h_wrap, w_v_wrap;
  logic [CNT_W-1:0] w_h_count, w_v_count;
  region_e          w_h_region, w_h_region_nxt, w_v_region, w_v_region_nxt;
  region_e          w_h_sel, w_v_sel;

  // Counters stay cleared unless running with lock held, so the entry edge never advances.
  assign w_running = (r_state == RUN) && bus.locked;
  assign w_h_adv   = w_running && bus.pix_en;
  assign w_v_adv   = w_h_adv && w_h_wrap;
  assign w_clear   = !w_running;

  vga_axis_counter #(
    .CNT_W     (CNT_W),
    .SEG_ACTIVE(H_ACTIVE),
    .SEG_FP    (H_FP),
    .SEG_SYNC  (H_SYNC),
    .SEG_BP    (H_BP)
  ) u_h_axis (
    .clk_in1     (clk_in1),
    .reset       (reset),
    .i_advance   (w_h_adv),
    .i_clear     (w_clear),
    .o_count     (w_h_count),
    .o_region    (w_h_region),
    .o_region_nxt(w_h_region_nxt),
    .o_wrap      (w_h_wrap)
  );

  vga_axis_counter #(
    .CNT_W     (CNT_W),
    .SEG_ACTIVE(V_ACTIVE),
    .SEG_FP    (V_FP),
    .SEG_SYNC  (V_SYNC),
    .SEG_BP    (V_BP)
  ) u_v_axis (
    .clk_in1     (clk_in1),
    .reset       (reset),
    .i_advance   (w_v_adv),
    .i_clear     (w_clear),
    .o_count     (w_v_count),
    .o_region    (w_v_region),
    .o_region_nxt(w_v_region_nxt),
    .o_wrap      (w_v_wrap)
  );

  always_comb begin
    w_state_d       = r_state;
    w_hsync_d       = ~SYNC_POL;
    w_vsync_d       = ~SYNC_POL;
    w_video_on_d    = 1'b0;
    w_line_start_d  = 1'b0;
    w_frame_start_d = 1'b0;
    w_h_sel         = bus.pix_en ? w_h_region_nxt : w_h_region;
    w_v_sel         = bus.pix_en ? w_v_region_nxt : w_v_region;
    unique case (r_state)
      IDLE: begin
        if (bus.locked) begin
          w_state_d       = RUN;
          w_video_on_d    = 1'b1;
          w_line_start_d  = 1'b1;
          w_frame_start_d = 1'b1;
        end
      end
      RUN: begin
        if (!bus.locked) begin
          w_state_d = IDLE;
        end else begin
          w_hsync_d       = sync_level(w_h_sel, SYNC_POL);
          w_vsync_d       = sync_level(w_v_sel, SYNC_POL);
          w_video_on_d    = (w_h_sel == ACTIVE) && (w_v_sel == ACTIVE);
          w_line_start_d  = w_h_adv && w_h_wrap;
          w_frame_start_d = w_v_adv && w_v_wrap;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in1 or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_video_on    <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_hsync       <= w_hsync_d;
      r_vsync       <= w_vsync_d;
      r_video_on    <= w_video_on_d;
      r_line_start  <= w_line_start_d;
      r_frame_start <= w_frame_start_d;
    end
  end

  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.video_on    = r_video_on;
  assign bus.pixel_x     = w_h_count;
  assign bus.pixel_y     = w_v_count;
  assign bus.line_start  = r_line_start;
  assign bus.frame_start = r_frame_start;

endmodule
